// File: rtl/weight_fetch_fifo_if.sv
// Handshake bundle for weight_fetch_fifo: fetch control, weight-memory read port
// and the row-FIFO head presented to the weight control unit.
interface weight_fetch_fifo_if #(
  parameter int MUL_SIZE   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int TILE_WIDTH = 8
) ();
  logic                             start_i;
  logic [ADDR_WIDTH-1:0]            base_addr_i;
  logic [TILE_WIDTH-1:0]            num_tiles_i;
  logic                             mem_rd_en_o;
  logic [ADDR_WIDTH-1:0]            mem_addr_o;
  logic [MUL_SIZE*DATA_WIDTH-1:0]   mem_data_i;
  logic                             weight_rd_i;
  logic                             weight_fifo_valid_o;
  logic [MUL_SIZE*DATA_WIDTH-1:0]   weight_row_o;
  logic                             busy_o;
  logic                             done_o;

  modport master (
    output start_i, base_addr_i, num_tiles_i, mem_data_i, weight_rd_i,
    input  mem_rd_en_o, mem_addr_o, weight_fifo_valid_o, weight_row_o, busy_o, done_o
  );

  modport slave (
    input  start_i, base_addr_i, num_tiles_i, mem_data_i, weight_rd_i,
    output mem_rd_en_o, mem_addr_o, weight_fifo_valid_o, weight_row_o, busy_o, done_o
  );
endinterface

// File: rtl/weight_fetch_fifo.sv
// Streams NUM_TILES*MUL_SIZE weight rows from memory into a credit-throttled
// row FIFO whose head feeds the weight control unit.
module weight_fetch_fifo #(
  parameter int MUL_SIZE   = 32,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 64,
  parameter int ADDR_WIDTH = 16,
  parameter int TILE_WIDTH = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  weight_fetch_fifo_if.slave bus
);

  localparam int ROW_W = MUL_SIZE * DATA_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rows_left_q;
  logic                  rd_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic                  done_q;

  logic [ROW_W-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [PTR_W:0]        count_q;
  logic                  push_pending_q;

  logic [PTR_W+1:0]      credit;
  logic                  issue;
  logic                  push;
  logic                  pop;

  // Every row already buffered or on its way counts against the depth, so a
  // granted read always has a slot; pops are not credited until they land.
  always_comb begin
    credit = (PTR_W+2)'(count_q) + (PTR_W+2)'(rd_en_q) + (PTR_W+2)'(push_pending_q);
    issue  = (state_q == FETCH) && (rows_left_q != '0) && (credit < (PTR_W+2)'(FIFO_DEPTH));
    push   = push_pending_q;
    pop    = bus.weight_rd_i && (count_q != '0);
  end

  // ---- stage 0: fetch control and memory read issue ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rows_left_q <= '0;
      rd_en_q     <= 1'b0;
      mem_addr_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      rd_en_q <= issue;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            if (bus.num_tiles_i != '0) begin
              addr_q      <= bus.base_addr_i;
              rows_left_q <= (ADDR_WIDTH+1)'(bus.num_tiles_i) * (ADDR_WIDTH+1)'(MUL_SIZE);
              state_q     <= FETCH;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (issue) begin
            mem_addr_q  <= addr_q;
            addr_q      <= addr_q + ADDR_WIDTH'(1);
            rows_left_q <= rows_left_q - (ADDR_WIDTH+1)'(1);
            if (rows_left_q == (ADDR_WIDTH+1)'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Last strobe has retired; its row is being written this cycle.
          if (!rd_en_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // ---- stage 1: returned row written into the FIFO ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      push_pending_q <= 1'b0;
    end else begin
      push_pending_q <= rd_en_q;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= bus.mem_data_i;
  end

  // Head row is forced to zero while empty so stale storage never shows.
  assign bus.weight_row_o        = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
  assign bus.weight_fifo_valid_o = (count_q != '0);
  assign bus.mem_rd_en_o         = rd_en_q;
  assign bus.mem_addr_o          = mem_addr_q;
  assign bus.busy_o              = (state_q != IDLE);
  assign bus.done_o              = done_q;

endmodule
